// File: rtl/dda_cmd_sequencer.sv
// dda_cmd_sequencer
// Buffers host velocity segments in a small FIFO and replays each one into the
// DDA pulse generator's 4-word buffer through the Nx/WR strobe handshake. The
// replay is throttled by Flag_full. An abort flushes all queued motion and
// pulses LS so the DDA also discards its buffered words.
//
// Ports
//   clk, rst_n        system clock shared with the DDA, async active-low reset
//   cmd_valid/ready   host push handshake for {cmd_vel, cmd_rep}
//   cmd_vel[7:0]      DDA word: bit 7 direction, bits 6:0 magnitude
//   cmd_rep[7:0]      DDA periods to repeat the word (0 behaves as 1)
//   start, abort      one-cycle pulses that set / clear the run flag
//   Flag_full         DDA buffer holds 4 words
//   Nx[7:0], WR, LS   word, write strobe and buffer clear to the DDA
//   busy              sequencer active or FIFO not empty
//   fifo_count        occupied FIFO entries
//   words_sent[15:0]  WR rising edges issued, wraps, cleared only by reset
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | nothing in flight; waits for run with a queued segment
// FETCH     | pops the FIFO head, loads Nx and the repeat count
// SETUP     | holds Nx until the DDA has room and run is set
// STROBE_HI | WR high for WR_HIGH cycles
// STROBE_LO | WR low for WR_LOW cycles, then next repeat / segment / idle
// ABORT     | LS high for LS_CYCLES cycles with FIFO and segment flushed

module dda_cmd_sequencer #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned WR_HIGH    = 2,
  parameter int unsigned WR_LOW     = 2,
  parameter int unsigned LS_CYCLES  = 2,
  localparam int unsigned AW        = $clog2(FIFO_DEPTH),
  localparam int unsigned CW        = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [7:0]    cmd_vel,
  input  logic [7:0]    cmd_rep,
  input  logic          start,
  input  logic          abort,
  input  logic          Flag_full,
  output logic [7:0]    Nx,
  output logic          WR,
  output logic          LS,
  output logic          busy,
  output logic [CW-1:0] fifo_count,
  output logic [15:0]   words_sent
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SETUP,
    S_STROBE_HI,
    S_STROBE_LO,
    S_ABORT
  } state_e;

  state_e        state_q, state_d;
  logic          run_q, run_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    rem_q, rem_d;
  logic [7:0]    tmr_q, tmr_d;
  logic [7:0]    nx_q, nx_d;
  logic          wr_q, wr_d;
  logic          ls_q, ls_d;
  logic [15:0]   words_q, words_d;

  logic [15:0]   mem_q [FIFO_DEPTH];
  logic          push;
  logic          pop;
  logic [7:0]    head_vel;
  logic [7:0]    head_rep;

  assign head_vel = mem_q[rd_ptr_q][15:8];
  assign head_rep = mem_q[rd_ptr_q][7:0];

  // Full blocks the push even when FETCH pops in the same cycle.
  assign cmd_ready = (count_q < CW'(FIFO_DEPTH)) && (state_q != S_ABORT);
  assign push      = cmd_valid && cmd_ready && !abort;

  assign busy       = (state_q != S_IDLE) || (count_q != '0);
  assign Nx         = nx_q;
  assign WR         = wr_q;
  assign LS         = ls_q;
  assign fifo_count = count_q;
  assign words_sent = words_q;

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    rem_d   = rem_q;
    nx_d    = nx_q;
    pop     = 1'b0;
    run_d   = run_q;

    if (abort) begin
      run_d = 1'b0;
    end else if (start) begin
      run_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (run_q && (count_q != '0)) begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        pop     = 1'b1;
        nx_d    = head_vel;
        rem_d   = (head_rep == 8'd0) ? 8'd1 : head_rep;
        state_d = S_SETUP;
      end
      S_SETUP: begin
        if (!Flag_full && run_q) begin
          state_d = S_STROBE_HI;
          tmr_d   = 8'(WR_HIGH - 1);
        end
      end
      S_STROBE_HI: begin
        if (tmr_q == 8'd0) begin
          state_d = S_STROBE_LO;
          tmr_d   = 8'(WR_LOW - 1);
        end else begin
          tmr_d = tmr_q - 8'd1;
        end
      end
      S_STROBE_LO: begin
        if (tmr_q == 8'd0) begin
          rem_d = rem_q - 8'd1;
          if (rem_d != 8'd0) begin
            state_d = S_SETUP;
          end else if (run_q && (count_q != '0)) begin
            state_d = S_FETCH;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          tmr_d = tmr_q - 8'd1;
        end
      end
      S_ABORT: begin
        if (tmr_q == 8'd0) begin
          state_d = S_IDLE;
        end else begin
          tmr_d = tmr_q - 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides everything, including a pop in FETCH; a repeat abort
    // while already aborting restarts the LS count.
    if (abort) begin
      state_d = S_ABORT;
      tmr_d   = 8'(LS_CYCLES - 1);
      rem_d   = 8'd0;
      nx_d    = 8'd0;
      pop     = 1'b0;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (abort) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Strobes are registered copies of the next state so they switch on the
  // same edge as the state, which truncates WR immediately on abort.
  assign wr_d    = (state_d == S_STROBE_HI);
  assign ls_d    = (state_d == S_ABORT);
  assign words_d = words_q + 16'((state_d == S_STROBE_HI) && (state_q != S_STROBE_HI));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      run_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rem_q    <= 8'd0;
      tmr_q    <= 8'd0;
      nx_q     <= 8'd0;
      wr_q     <= 1'b0;
      ls_q     <= 1'b0;
      words_q  <= 16'd0;
    end else begin
      state_q  <= state_d;
      run_q    <= run_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rem_q    <= rem_d;
      tmr_q    <= tmr_d;
      nx_q     <= nx_d;
      wr_q     <= wr_d;
      ls_q     <= ls_d;
      words_q  <= words_d;
    end
  end

  // Storage has no reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {cmd_vel, cmd_rep};
    end
  end

endmodule

// File: tb/tb_dda_cmd_sequencer.sv
module tb_dda_cmd_sequencer;

  localparam int DEPTH = 8;
  localparam int WRH   = 2;
  localparam int WRL   = 2;
  localparam int LSC   = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        Flag_full = 1'b0;
  logic [7:0]  cmd_vel = 8'd0;
  logic [7:0]  cmd_rep = 8'd0;
  logic        cmd_ready;
  logic        WR;
  logic        LS;
  logic        busy;
  logic [7:0]  Nx;
  logic [3:0]  fifo_count;
  logic [15:0] words_sent;

  dda_cmd_sequencer #(
    .FIFO_DEPTH(DEPTH), .WR_HIGH(WRH), .WR_LOW(WRL), .LS_CYCLES(LSC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_vel(cmd_vel), .cmd_rep(cmd_rep), .start(start), .abort(abort),
    .Flag_full(Flag_full), .Nx(Nx), .WR(WR), .LS(LS), .busy(busy),
    .fifo_count(fifo_count), .words_sent(words_sent)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_chk = 0;
  int         n_pass = 0;
  logic [7:0] exp_q[$];     // words the DDA should still receive, in order
  int         rise_q[$];    // cycle numbers of observed WR rising edges
  int         total_words = 0;
  bit         wid_skip = 1'b0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference model: a segment expands into max(rep,1) copies of its word.
  function automatic void model_push(input logic [7:0] v, input logic [7:0] r);
    int n;
    n = (r == 8'd0) ? 1 : int'(r);
    for (int k = 0; k < n; k++) exp_q.push_back(v);
    total_words += n;
  endfunction

  task automatic do_reset;
    rst_n = 1'b0; cmd_valid = 1'b0; start = 1'b0; abort = 1'b0; Flag_full = 1'b0;
    repeat (2) tick;
    rst_n = 1'b1;
    exp_q.delete();
    rise_q.delete();
    total_words = 0;
    wid_skip = 1'b0;
    tick;
  endtask

  task automatic try_push(input logic [7:0] v, input logic [7:0] r, output bit acc);
    cmd_valid = 1'b1; cmd_vel = v; cmd_rep = r;
    acc = cmd_ready && !abort;
    if (acc) model_push(v, r);
    tick;
    cmd_valid = 1'b0;
  endtask

  task automatic push(input logic [7:0] v, input logic [7:0] r);
    int n = 0;
    bit acc;
    while (!cmd_ready && n < 200) begin tick; n++; end
    if (n >= 200) check("push_ready_wait", cmd_ready, 1);
    try_push(v, r, acc);
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int bound, input string tag);
    int n = 0;
    while ((busy || WR) && n < bound) begin tick; n++; end
    check(tag, busy, 0);
  endtask

  task automatic wait_wr(input int bound, input string tag);
    int n = 0;
    while (!WR && n < bound) begin tick; n++; end
    check(tag, WR, 1);
  endtask

  task automatic wait_ls_done(output int len);
    len = 0;
    while (LS && len < 20) begin tick; len++; end
  endtask

  // WR monitor: each rising edge must carry the next expected word, Nx must
  // not move while WR is high, and untruncated pulses last WR_HIGH cycles.
  initial begin
    logic       wr_prev = 1'b0;
    logic [7:0] nx_rise = 8'd0;
    int         hi_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        wr_prev = 1'b0;
        hi_cnt = 0;
      end else begin
        if (WR && !wr_prev) begin
          rise_q.push_back(cyc);
          nx_rise = Nx;
          if (exp_q.size() == 0) check("wr_unexpected_queue_len", exp_q.size(), 1);
          else check("nx_word", Nx, exp_q.pop_front());
        end
        if (WR && wr_prev) check("nx_hold_during_wr", Nx, nx_rise);
        if (WR) hi_cnt = (wr_prev ? hi_cnt : 0) + 1;
        else begin
          if (wr_prev && !wid_skip) check("wr_width", hi_cnt, WRH);
          hi_cnt = 0;
        end
        wr_prev = WR;
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         c0, s, len;
    bit         acc;
    logic [7:0] reps[8];
    bit         seg_end[$];

    // ---- reset state ----
    do_reset;
    check("rst_nx", Nx, 0);
    check("rst_wr", WR, 0);
    check("rst_ls", LS, 0);
    check("rst_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_count", fifo_count, 0);
    check("rst_words", words_sent, 0);

    // ---- single segment: 8'h85 x3 ----
    pulse_start;
    c0 = cyc;
    try_push(8'h85, 8'd3, acc);
    wait_idle(100, "seg_idle");
    check("seg_rises", rise_q.size(), 3);
    if (rise_q.size() == 3) begin
      check("seg_first_wr_latency", rise_q[0] - c0, 4);
      check("seg_period_1", rise_q[1] - rise_q[0], 1 + WRH + WRL);
      check("seg_period_2", rise_q[2] - rise_q[1], 1 + WRH + WRL);
    end
    check("seg_words_sent", words_sent, 3);
    check("seg_nx_kept", Nx, 8'h85);

    // ---- backpressure ----
    do_reset;
    pulse_start;
    Flag_full = 1'b1;
    try_push(8'h3C, 8'd1, acc);
    repeat (10) tick;
    check("bp_no_wr", rise_q.size(), 0);
    check("bp_nx_stable", Nx, 8'h3C);
    check("bp_busy", busy, 1);
    // Flag_full low during this cycle is seen by SETUP at the next edge.
    Flag_full = 1'b0;
    tick;
    check("bp_wr_after_release", WR, 1);
    wait_idle(50, "bp_idle");
    check("bp_words_sent", words_sent, 1);

    // ---- FIFO full, then in-order drain ----
    do_reset;
    reps = '{8'd0, 8'd1, 8'd2, 8'd0, 8'd3, 8'd1, 8'd0, 8'd2};
    for (int i = 0; i < DEPTH; i++) begin
      int n;
      push(8'($urandom), reps[i]);
      n = (reps[i] == 8'd0) ? 1 : int'(reps[i]);
      for (int k = 0; k < n; k++) seg_end.push_back(k == n - 1);
    end
    check("full_count", fifo_count, DEPTH);
    check("full_ready", cmd_ready, 0);
    try_push(8'hAA, 8'd1, acc);
    check("full_9th_accepted", acc, 0);
    check("full_count_after_9th", fifo_count, DEPTH);
    s = cyc;
    pulse_start;
    wait_idle(400, "full_drain_idle");
    check("full_leftover", exp_q.size(), 0);
    check("full_words_sent", words_sent, 12);
    check("full_rises", rise_q.size(), 12);
    if (rise_q.size() == 12) begin
      check("full_start_latency", rise_q[0] - s, 4);
      for (int j = 0; j < 11; j++)
        check("full_gap", rise_q[j+1] - rise_q[j], seg_end[j] ? 6 : 5);
    end

    // ---- abort in first WR-high cycle with 5 still queued ----
    do_reset;
    for (int i = 0; i < 6; i++) push(8'(8'h10 + i), 8'd1);
    pulse_start;
    wait_wr(20, "ab_first_wr");
    check("ab_queued", fifo_count, 5);
    wid_skip = 1'b1;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    exp_q.delete();
    check("ab_wr", WR, 0);
    check("ab_nx", Nx, 0);
    check("ab_ls", LS, 1);
    check("ab_count", fifo_count, 0);
    check("ab_ready", cmd_ready, 0);
    wait_ls_done(len);
    check("ab_ls_len", len, LSC);
    check("ab_busy", busy, 0);
    check("ab_ready_after", cmd_ready, 1);
    wid_skip = 1'b0;
    try_push(8'h77, 8'd2, acc);
    repeat (15) tick;
    check("ab_run_cleared", rise_q.size(), 1);
    check("ab_count_pending", fifo_count, 1);
    pulse_start;
    wait_idle(60, "ab_idle");
    check("ab_leftover", exp_q.size(), 0);
    check("ab_words_sent", words_sent, 3);

    // ---- simultaneous events ----
    do_reset;
    start = 1'b1; abort = 1'b1;
    tick;
    start = 1'b0; abort = 1'b0;
    check("sa_ls", LS, 1);
    wait_ls_done(len);
    check("sa_ls_len", len, LSC);
    try_push(8'h5A, 8'd1, acc);
    repeat (12) tick;
    check("sa_run_low", rise_q.size(), 0);
    check("sa_count", fifo_count, 1);
    abort = 1'b1;
    try_push(8'h66, 8'd1, acc);
    abort = 1'b0;
    exp_q.delete();
    check("pa_count", fifo_count, 0);
    check("pa_ls", LS, 1);
    wait_ls_done(len);
    check("pa_busy", busy, 0);
    pulse_start;
    repeat (12) tick;
    check("pa_nothing_sent", rise_q.size(), 0);

    // ---- random traffic with random backpressure ----
    do_reset;
    pulse_start;
    for (int i = 0; i < 800; i++) begin
      Flag_full = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1) try_push(8'($urandom), 8'($urandom_range(0, 3)), acc);
      else tick;
    end
    Flag_full = 1'b0;
    wait_idle(4000, "rnd_idle");
    check("rnd_leftover", exp_q.size(), 0);
    check("rnd_words_sent", words_sent, total_words & 16'hFFFF);

    // ---- reset mid-strobe ----
    pulse_start;
    try_push(8'h11, 8'd1, acc);
    try_push(8'h22, 8'd1, acc);
    wait_wr(20, "rm_wr");
    wid_skip = 1'b1;
    rst_n = 1'b0;
    #1;
    check("rm_wr_async", WR, 0);
    check("rm_count", fifo_count, 0);
    check("rm_words", words_sent, 0);
    do_reset;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
